// File: rtl/core_pc_ctrl.sv
// Program counter owner for the core: arbitrates jump / hold / halt requests from
// execute, the fetch bus and debug, and drives pipeline hold levels and flushes.
module core_pc_ctrl #(
  parameter logic [31:0] RST_ADDR     = 32'h0000_0000,
  parameter int          PC_STEP      = 4,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_hold_flag_in,
  input  logic        ex_jump_flag_in,
  input  logic [31:0] ex_jump_addr_in,
  input  logic        bus_hold_flag_in,
  input  logic        halt_req_in,
  output logic [31:0] pc_out,
  output logic        inst_valid_out,
  output logic [1:0]  hold_level_out,
  output logic        flush_out,
  output logic        halted_out
);

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          jump;
  logic [31:0]   jump_tgt;

  // Masking keeps the target word-aligned; the low address bits are simply dropped.
  assign jump_tgt = ex_jump_addr_in & ~32'h3;
  assign jump     = ex_jump_flag_in && (state != HALT);
  assign flush_out = jump || (state == FLUSH);

  always_comb begin
    hold_level_out = 2'd0;
    if (state == HALT)         hold_level_out = 2'd3;
    else if (jump)             hold_level_out = 2'd0;
    else if (ex_hold_flag_in)  hold_level_out = 2'd3;
    else if (bus_hold_flag_in) hold_level_out = 2'd2;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_out         <= RST_ADDR;
      state          <= RUN;
      cnt            <= '0;
      inst_valid_out <= 1'b0;
      halted_out     <= 1'b0;
    end else begin
      case (state)
        HALT: begin
          if (!halt_req_in) begin
            state          <= RUN;
            inst_valid_out <= 1'b1;
            halted_out     <= 1'b0;
          end else begin
            inst_valid_out <= 1'b0;
            halted_out     <= 1'b1;
          end
        end
        default: begin
          inst_valid_out <= 1'b1;
          halted_out     <= 1'b0;
          if (jump) begin
            pc_out <= jump_tgt;
            if (FLUSH_CYCLES > 1) begin
              state <= FLUSH;
              cnt   <= CW'(FLUSH_CYCLES - 1);
            end else begin
              state <= RUN;
              cnt   <= '0;
            end
          end else if (hold_level_out == 2'd0) begin
            pc_out <= pc_out + 32'(PC_STEP);
            if (state == FLUSH) begin
              // Halt is only considered once the flush window has closed.
              cnt <= cnt - CW'(1);
              if (cnt == CW'(1)) state <= RUN;
            end else if (halt_req_in) begin
              state          <= HALT;
              inst_valid_out <= 1'b0;
              halted_out     <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/core_pc_ctrl.md
Name: core_pc_ctrl

Overview:
- Receiving end of the execute stage's control request interface (hold flag, jump flag, jump address).
- Owns the program counter, arbitrates jump, hold and halt requests, and issues pipeline hold levels and flush pulses to the fetch/decode/execute registers.
- Sits between core_ex, the instruction-fetch bus port and the pipeline register stages.

Parameters:
- RST_ADDR, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, sequential PC increment in bytes.
- FLUSH_CYCLES, 2, total cycles flush_out stays asserted after an accepted jump (minimum 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- ex_hold_flag_in  in  1  execute stage requests a pipeline hold (1 = hold).
- ex_jump_flag_in  in  1  execute stage requests a jump (1 = jump).
- ex_jump_addr_in  in  32  jump target.
- bus_hold_flag_in  in  1  fetch bus not ready this cycle.
- halt_req_in  in  1  debug halt request, level-sensitive.
- pc_out  out  32  current fetch address (registered).
- inst_valid_out  out  1  fetch request valid.
- hold_level_out  out  2  0 none, 1 hold PC, 2 hold PC+IF/ID, 3 hold PC+IF/ID+ID/EX.
- flush_out  out  1  invalidate IF/ID and ID/EX contents.
- halted_out  out  1  core is in HALT.

Behaviour:
- Reset: async on rst=0. Immediately sets pc_out=RST_ADDR, state=RUN, flush counter=0, hold_level_out=0, flush_out=0, halted_out=0, inst_valid_out=0. Reset mid-operation aborts any flush or halt with no residue.
- inst_valid_out: registered. 0 in the first cycle after reset release, then 1 in RUN/FLUSH. 0 in HALT.
- States:
  - RUN: normal operation.
  - FLUSH: counting flush cycles after a jump.
  - HALT: stopped.
- Request priority each cycle in RUN/FLUSH: jump > ex_hold > bus_hold > halt > sequential.
- Jump accepted (ex_jump_flag_in=1, state≠HALT):
  - pc_out <= {ex_jump_addr_in[31:2],2'b00} at next edge.
  - flush_out=1 combinationally in the same cycle.
  - If FLUSH_CYCLES>1: state->FLUSH with counter=FLUSH_CYCLES-1. Otherwise stay RUN.
  - A jump overrides any simultaneous hold: hold_level_out=0 that cycle.
- FLUSH:
  - flush_out=1.
  - PC advances by PC_STEP when hold_level_out=0.
  - Counter decrements only when hold_level_out=0. The state returns to RUN on the edge where the counter goes 1->0.
  - A new jump in FLUSH reloads the counter and retargets the PC.
- flush_out = ex_jump_flag_in (state≠HALT) OR state==FLUSH. Total assertion is exactly FLUSH_CYCLES cycles absent holds.
- Holds (no jump):
  - ex_hold_flag_in=1 -> level 3.
  - Else bus_hold_flag_in=1 -> level 2.
  - Both -> level 3.
  - hold_level_out is combinational. pc_out is unchanged while level≥1.
- Sequential: pc_out <= pc_out + PC_STEP, modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
- HALT entry: halt_req_in=1 in RUN with no jump and no hold -> HALT at next edge. A pending jump or hold defers entry; halt is taken in FLUSH only after it completes.
- HALT:
  - pc_out frozen; hold_level_out=3; flush_out=0; halted_out=1 (registered, asserted from the first HALT cycle).
  - ex_jump_flag_in and hold inputs are ignored.
  - halt_req_in=0 -> RUN at next edge. The PC resumes from the frozen value.
- All outputs are glitch-free registered values except hold_level_out and flush_out, which are combinational from registered state and current inputs.

Test Plan:
- Reset release, no requests, 4 cycles -> pc_out 0x0,0x4,0x8,0xC. inst_valid_out 0 then 1. hold_level_out 0, flush_out 0.
- At pc=0x10, jump pulse with addr 0x0000_0103, FLUSH_CYCLES=2 -> flush_out high for exactly 2 cycles. pc_out 0x100 then 0x104. State back to RUN.
- bus_hold for 3 cycles at pc=0x20, with ex_hold overlapping the middle cycle -> hold_level_out 2,3,2. pc_out stays 0x20, then resumes at 0x24.
- Jump and ex_hold in the same cycle -> hold_level_out 0, jump taken. Second jump to 0x200 during FLUSH -> counter reloads, flush_out extends 2 more cycles, pc_out=0x200.
- halt_req_in raised at pc=0x40 -> halted_out=1, pc frozen at 0x44 (PC has already advanced from 0x40 on the entry edge), hold_level_out=3, jump pulses ignored. Release -> pc_out 0x48 next. Reset asserted mid-HALT -> pc_out=RST_ADDR immediately, halted_out=0.
- pc_out preset via jump to 0xFFFF_FFF8, 3 sequential cycles -> 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
